// File: rtl/dffsr_pipe_pkg.sv
// Shared defaults, legal parameter ranges and mask resolution for the dffsr_pipe slice.
package dffsr_pipe_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  // Clear wins over set on any bit where both masks are high.
  function automatic logic [63:0] resolve_mask(input logic [63:0] data,
                                               input logic [63:0] set_bits,
                                               input logic [63:0] clr_bits);
    return (data | set_bits) & ~clr_bits;
  endfunction

endpackage

// File: rtl/dffsr_pipe_stage.sv
// One pipeline stage: WIDTH data flops plus a valid flop, with enable hold and per-bit set/clear.
module dffsr_pipe_stage
  import dffsr_pipe_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] set_mask,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] q,
  output logic             valid_q
);

  logic [WIDTH-1:0] shifted;

  assign shifted = EN ? d_in : q;

  // Masks act on the post-shift value every edge, independent of EN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q       <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      q <= WIDTH'(resolve_mask(64'(shifted), 64'(set_mask), 64'(clr_mask)));
      if (EN) begin
        valid_q <= valid_in;
      end
    end
  end

endmodule

// File: rtl/dffsr_pipe.sv
// DEPTH-stage register pipeline with synchronous per-bit set/clear masks.
// Define DFFSR_PIPE_CONFLICT_EN to add the sticky ERR output for set/clear conflicts.
module dffsr_pipe
  import dffsr_pipe_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               DEPTH     = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID_IN,
  input  logic [WIDTH-1:0] SET_MASK,
  input  logic [WIDTH-1:0] CLR_MASK,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             VALID_OUT
`ifdef DFFSR_PIPE_CONFLICT_EN
  ,
  output logic             ERR
`endif
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("dffsr_pipe: WIDTH %0d outside legal range", WIDTH);
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("dffsr_pipe: DEPTH %0d outside legal range", DEPTH);
  end

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic             stage_v;

    if (i == 0) begin : g_head
      assign stage_d = D;
      assign stage_v = VALID_IN;
    end else begin : g_body
      assign stage_d = stage_data[i-1];
      assign stage_v = stage_valid[i-1];
    end

    dffsr_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .CLK      (CLK),
      .RST      (RST),
      .EN       (EN),
      .d_in     (stage_d),
      .valid_in (stage_v),
      .set_mask (SET_MASK),
      .clr_mask (CLR_MASK),
      .q        (stage_data[i]),
      .valid_q  (stage_valid[i])
    );
  end

  assign Q         = stage_data[DEPTH-1];
  assign QN        = ~stage_data[DEPTH-1];
  assign VALID_OUT = stage_valid[DEPTH-1];

`ifdef DFFSR_PIPE_CONFLICT_EN
  // Sticky conflict flag; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (|(SET_MASK & CLR_MASK)) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dffsr_pipe.sv
// Directed self-checking bench for dffsr_pipe (WIDTH=8, DEPTH=2, RESET_VAL=8'hA5).
module tb_dffsr_pipe;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [7:0] D;
  logic       VALID_IN;
  logic [7:0] SET_MASK;
  logic [7:0] CLR_MASK;
  logic [7:0] Q;
  logic [7:0] QN;
  logic       VALID_OUT;
`ifdef DFFSR_PIPE_CONFLICT_EN
  logic       ERR;
`endif

  int checks   = 0;
  int failures = 0;

  dffsr_pipe #(
    .WIDTH     (8),
    .DEPTH     (2),
    .RESET_VAL (8'hA5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .D         (D),
    .VALID_IN  (VALID_IN),
    .SET_MASK  (SET_MASK),
    .CLR_MASK  (CLR_MASK),
    .Q         (Q),
    .QN        (QN),
    .VALID_OUT (VALID_OUT)
`ifdef DFFSR_PIPE_CONFLICT_EN
    ,
    .ERR       (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  // Drive one set of inputs across a single rising edge, then settle.
  task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] d,
                               input logic vin, input logic [7:0] set_m,
                               input logic [7:0] clr_m);
    RST      = rst;
    EN       = en;
    D        = d;
    VALID_IN = vin;
    SET_MASK = set_m;
    CLR_MASK = clr_m;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1'b0; EN = 1'b0; D = '0; VALID_IN = 1'b0; SET_MASK = '0; CLR_MASK = '0;
    @(negedge CLK);

    // Reset value on every stage
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("reset_q", Q, 8'hA5);
    checkOutput("reset_qn", QN, 8'h5A);
    checkOutput("reset_vout", VALID_OUT, 0);

    // Two-edge latency
    applyStimulus(0, 1, 8'h3C, 1, 8'h00, 8'h00);
    checkOutput("lat_e1_q", Q, 8'hA5);
    checkOutput("lat_e1_vout", VALID_OUT, 0);
    applyStimulus(0, 1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("lat_e2_q", Q, 8'h3C);
    checkOutput("lat_e2_vout", VALID_OUT, 1);
    applyStimulus(0, 1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("lat_e3_q", Q, 8'h00);
    checkOutput("lat_e3_vout", VALID_OUT, 0);

    // Hold with EN low
    applyStimulus(0, 1, 8'h11, 1, 8'h00, 8'h00);
    applyStimulus(0, 1, 8'h22, 1, 8'h00, 8'h00);
    checkOutput("hold_load_q", Q, 8'h11);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h99, 0, 8'h00, 8'h00);
      checkOutput("hold_q", Q, 8'h11);
      checkOutput("hold_stage0", dut.stage_data[0], 8'h22);
      checkOutput("hold_vout", VALID_OUT, 1);
    end
    applyStimulus(0, 1, 8'h33, 0, 8'h00, 8'h00);
    checkOutput("hold_release_q", Q, 8'h22);

    // Masks applied with EN low; clear beats set on bit 0
    applyStimulus(0, 1, 8'h0F, 1, 8'h00, 8'h00);
    applyStimulus(0, 1, 8'h0F, 1, 8'h00, 8'h00);
    checkOutput("mask_pre_q", Q, 8'h0F);
    applyStimulus(0, 0, 8'h00, 0, 8'hF0, 8'h01);
    checkOutput("mask_q", Q, 8'hFE);
    checkOutput("mask_qn", QN, 8'h01);
    checkOutput("mask_stage0", dut.stage_data[0], 8'hFE);
    checkOutput("mask_vout", VALID_OUT, 1);

    // Set/clear conflict on bit 7
    applyStimulus(0, 0, 8'h00, 0, 8'h80, 8'h80);
    checkOutput("conflict_q", Q, 8'h7E);
`ifdef DFFSR_PIPE_CONFLICT_EN
    checkOutput("conflict_err", ERR, 1);
`endif
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("conflict_hold_q", Q, 8'h7E);
`ifdef DFFSR_PIPE_CONFLICT_EN
    checkOutput("conflict_err_sticky", ERR, 1);
`endif

    // Reset beats enable and masks
    applyStimulus(1, 1, 8'h55, 1, 8'hFF, 8'h00);
    checkOutput("rst_prio_q", Q, 8'hA5);
    checkOutput("rst_prio_vout", VALID_OUT, 0);
`ifdef DFFSR_PIPE_CONFLICT_EN
    checkOutput("rst_err_clear", ERR, 0);
`endif

    // Reset mid-stream discards in-flight data
    applyStimulus(0, 1, 8'h77, 1, 8'h00, 8'h00);
    applyStimulus(1, 1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("mid_rst_q", Q, 8'hA5);
    checkOutput("mid_rst_vout", VALID_OUT, 0);
    applyStimulus(0, 1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("mid_rst_e1_q", Q, 8'hA5);
    checkOutput("mid_rst_e1_vout", VALID_OUT, 0);
    applyStimulus(0, 1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("mid_rst_e2_q", Q, 8'h00);
    checkOutput("mid_rst_e2_vout", VALID_OUT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
